alu_req_scheduler: RTL and testbench

//  Shares one combinational 8-bit ALU (3-bit opcode, 16-bit result, carry/zero flags) among NUM_REQ requesters.

---
 rtl/alu_ctrl_pkg.sv | 44 ++++
 rtl/rr_arbiter.sv | 61 ++++++
 rtl/alu_req_scheduler.sv | 151 +++++++++++++++
 tb/tb_alu_req_scheduler.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU request scheduler: opcode encodings, FSM
// state encoding, fixed ALU widths, op/response payload structs and a helper
// that tells which opcodes produce a meaningful carry.
package alu_ctrl_pkg;

    localparam int unsigned ALU_OP_W   = 3;
    localparam int unsigned ALU_DATA_W = 8;
    localparam int unsigned ALU_RES_W  = 16;

    localparam logic [ALU_OP_W-1:0] OP_ADD  = 3'b000;
    localparam logic [ALU_OP_W-1:0] OP_SUB  = 3'b001;
    localparam logic [ALU_OP_W-1:0] OP_MUL  = 3'b010;
    localparam logic [ALU_OP_W-1:0] OP_AND  = 3'b011;
    localparam logic [ALU_OP_W-1:0] OP_OR   = 3'b100;
    localparam logic [ALU_OP_W-1:0] OP_NAND = 3'b101;
    localparam logic [ALU_OP_W-1:0] OP_NOR  = 3'b110;
    localparam logic [ALU_OP_W-1:0] OP_XOR  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Operation as presented to the ALU inputs
    typedef struct packed {
        logic [ALU_OP_W-1:0]   op;
        logic [ALU_DATA_W-1:0] a;
        logic [ALU_DATA_W-1:0] b;
    } alu_req_t;

    // Captured ALU response returned to the requester
    typedef struct packed {
        logic [ALU_RES_W-1:0] result;
        logic                 carry;
        logic                 zero;
    } alu_rsp_t;

    // The ALU only updates its carry flag on ADD/SUB; other ops leave it stale
    function automatic logic op_has_carry(input logic [ALU_OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter.
//  clk, rst_n : clock, async active-low reset (pointer -> requester 0)
//  req        : request vector
//  advance    : move pointer to adv_idx+1 (wrapping) at the next edge
//  adv_idx    : index the pointer advances past
//  grant      : one-hot winner among req, starting search at the pointer
//  grant_idx  : binary index of grant (0 when nothing requested)
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    input  logic [IDX_W-1:0]   adv_idx,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic             found;

    // Priority pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Pointer moves just past the requester that was served
    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = (adv_idx == IDX_W'(NUM_REQ - 1)) ? '0 : adv_idx + 1'b1;
        end
    end

    // First active request at or after the pointer, wrapping around
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            int unsigned j;
            j = 32'(ptr_q) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!found && req[IDX_W'(j)]) begin
                found              = 1'b1;
                grant[IDX_W'(j)]   = 1'b1;
                grant_idx          = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/alu_req_scheduler.sv
// Shares one combinational ALU among NUM_REQ requesters. A round-robin
// winner's op is registered onto the ALU inputs, the result and flags are
// captured one cycle later and returned over a per-requester valid/ready.
//  clk, rst_n          : clock, async active-low reset
//  req_valid/req_ready : op request handshake (req_ready one-hot or zero)
//  req_op/req_a/req_b  : per-requester opcode and operands, slice i
//  rsp_valid/rsp_ready : response handshake, rsp_valid one-hot to grantee
//  rsp_result/carry/zero : response payload
//  alu_operation/alu_operand_A/alu_operand_B : registered ALU inputs
//  alu_result/alu_carry_flag/alu_zero_flag   : ALU outputs
//  busy                : high whenever an op is in flight
module alu_req_scheduler
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned DATA_W  = ALU_DATA_W,
    parameter int unsigned RES_W   = ALU_RES_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [3*NUM_REQ-1:0]      req_op,
    input  logic [DATA_W*NUM_REQ-1:0] req_a,
    input  logic [DATA_W*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [RES_W-1:0]          rsp_result,
    output logic                      rsp_carry,
    output logic                      rsp_zero,
    output logic [2:0]                alu_operation,
    output logic [DATA_W-1:0]         alu_operand_A,
    output logic [DATA_W-1:0]         alu_operand_B,
    input  logic [RES_W-1:0]          alu_result,
    input  logic                      alu_carry_flag,
    input  logic                      alu_zero_flag,
    output logic                      busy
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    grant_q, grant_d;
    alu_req_t            issue_q, issue_d;
    alu_rsp_t            rsp_q, rsp_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic                busy_q, busy_d;

    logic [NUM_REQ-1:0]  arb_grant;
    logic [IDX_W-1:0]    arb_idx;
    logic                advance;
    alu_req_t            sel;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_valid),
        .advance   (advance),
        .adv_idx   (grant_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    // Accept is only offered while idle
    assign req_ready = (state_q == ST_IDLE) ? arb_grant : '0;

    // Payload of the current arbitration winner
    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == IDX_W'(i)) begin
                sel.op = ALU_OP_W'(req_op[ALU_OP_W*i +: ALU_OP_W]);
                sel.a  = ALU_DATA_W'(req_a[DATA_W*i +: DATA_W]);
                sel.b  = ALU_DATA_W'(req_b[DATA_W*i +: DATA_W]);
            end
        end
    end

    // State, ALU input, response and grant registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            issue_q     <= '0;
            rsp_q       <= '0;
            rsp_valid_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            issue_q     <= issue_d;
            rsp_q       <= rsp_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state and register update logic
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        issue_d     = issue_q;
        rsp_d       = rsp_q;
        rsp_valid_d = rsp_valid_q;
        advance     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|arb_grant) begin
                    issue_d = sel;
                    grant_d = arb_idx;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // Carry is only meaningful for ADD/SUB; mask the stale flag otherwise
                rsp_d.result = ALU_RES_W'(alu_result);
                rsp_d.carry  = op_has_carry(issue_q.op) ? alu_carry_flag : 1'b0;
                rsp_d.zero   = alu_zero_flag;
                rsp_valid_d  = NUM_REQ'(1) << grant_q;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready[grant_q]) begin
                    rsp_valid_d = '0;
                    advance     = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                rsp_valid_d = '0;
                state_d     = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign rsp_valid     = rsp_valid_q;
    assign rsp_result    = RES_W'(rsp_q.result);
    assign rsp_carry     = rsp_q.carry;
    assign rsp_zero      = rsp_q.zero;
    assign alu_operation = issue_q.op;
    assign alu_operand_A = DATA_W'(issue_q.a);
    assign alu_operand_B = DATA_W'(issue_q.b);
    assign busy          = busy_q;

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Bench for alu_req_scheduler: a behavioural ALU model, directed requests with
// hand-computed expected responses pushed to a queue, and a monitor that pops
// and compares on every response handshake.
module tb_alu_req_scheduler;
    import alu_ctrl_pkg::*;

    localparam int unsigned N = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [3*N-1:0]  req_op = '0;
    logic [8*N-1:0]  req_a = '0;
    logic [8*N-1:0]  req_b = '0;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready = '0;
    logic [15:0]     rsp_result;
    logic            rsp_carry;
    logic            rsp_zero;
    logic [2:0]      alu_operation;
    logic [7:0]      alu_operand_A;
    logic [7:0]      alu_operand_B;
    logic [15:0]     alu_result;
    logic            alu_carry_flag;
    logic            alu_zero_flag;
    logic            busy;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int          idx;
        logic [15:0] res;
        logic        c;
        logic        z;
    } exp_t;

    exp_t q[$];
    exp_t e;

    always #5 clk = ~clk;

    alu_req_scheduler #(.NUM_REQ(N)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_a          (req_a),
        .req_b          (req_b),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_result     (rsp_result),
        .rsp_carry      (rsp_carry),
        .rsp_zero       (rsp_zero),
        .alu_operation  (alu_operation),
        .alu_operand_A  (alu_operand_A),
        .alu_operand_B  (alu_operand_B),
        .alu_result     (alu_result),
        .alu_carry_flag (alu_carry_flag),
        .alu_zero_flag  (alu_zero_flag),
        .busy           (busy)
    );

    // ALU model; carry sits at a stale 1 for ops that do not update it
    always_comb begin
        alu_result     = '0;
        alu_carry_flag = 1'b1;
        case (alu_operation)
            OP_ADD: begin
                alu_result     = 16'(alu_operand_A) + 16'(alu_operand_B);
                alu_carry_flag = alu_result[8];
            end
            OP_SUB: begin
                alu_result     = 16'(alu_operand_A) - 16'(alu_operand_B);
                alu_carry_flag = (alu_operand_A < alu_operand_B);
            end
            OP_MUL:  alu_result = 16'(alu_operand_A) * 16'(alu_operand_B);
            OP_AND:  alu_result = {8'h00, alu_operand_A & alu_operand_B};
            OP_OR:   alu_result = {8'h00, alu_operand_A | alu_operand_B};
            OP_NAND: alu_result = {8'h00, ~(alu_operand_A & alu_operand_B)};
            OP_NOR:  alu_result = {8'h00, ~(alu_operand_A | alu_operand_B)};
            default: alu_result = {8'h00, alu_operand_A ^ alu_operand_B};
        endcase
        alu_zero_flag = (alu_result == 16'h0000);
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Response monitor: pops one expectation per response handshake
    always @(negedge clk) begin
        if (rst_n) begin
            chk("req_ready_onehot0", 32'($onehot0(req_ready)), 32'(1));
            if ((rsp_valid & rsp_ready) != '0) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rsp actual rsp_valid=0x%0h required no response at %0t", rsp_valid, $time);
                end else begin
                    e = q.pop_front();
                    chk("rsp_idx",    32'(rsp_valid),  32'(1) << e.idx);
                    chk("rsp_result", 32'(rsp_result), 32'(e.res));
                    chk("rsp_carry",  32'(rsp_carry),  32'(e.c));
                    chk("rsp_zero",   32'(rsp_zero),   32'(e.z));
                end
            end
        end
    end

    task automatic set_req(input int idx, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        req_op[3*idx +: 3] = op;
        req_a[8*idx +: 8]  = a;
        req_b[8*idx +: 8]  = b;
    endtask

    // Wait for req_ready[idx], optionally push the expected response, then pass the accept edge
    task automatic accept(input int idx, input bit push, input logic [15:0] res,
                          input logic c, input logic z, input bit drop);
        int n;
        exp_t x;
        @(negedge clk);
        n = 0;
        while (!req_ready[idx] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("grant", 32'(req_ready), 32'(1) << idx);
        if (push) begin
            x.idx = idx; x.res = res; x.c = c; x.z = z;
            q.push_back(x);
        end
        @(posedge clk);
        #1;
        if (drop) req_valid[idx] = 1'b0;
    endtask

    // Single request from idx, with EXEC-cycle and latency checks
    task automatic do_req(input int idx, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] res, input logic c, input logic z, input bit push);
        @(posedge clk);
        #1;
        set_req(idx, op, a, b);
        req_valid[idx] = 1'b1;
        accept(idx, push, res, c, z, 1'b1);
        @(negedge clk);
        chk("exec_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("exec_busy",      32'(busy),      32'(1));
        chk("exec_alu_op",    32'(alu_operation), 32'(op));
        chk("exec_alu_a",     32'(alu_operand_A), 32'(a));
        chk("exec_alu_b",     32'(alu_operand_B), 32'(b));
        @(negedge clk);
        chk("latency_rsp_valid", 32'(rsp_valid), 32'(1) << idx);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 32'(q.size()), 32'(0));
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_req_ready"},  32'(req_ready),     32'(0));
        chk({tag, "_rsp_valid"},  32'(rsp_valid),     32'(0));
        chk({tag, "_busy"},       32'(busy),          32'(0));
        chk({tag, "_alu_op"},     32'(alu_operation), 32'(0));
        chk({tag, "_alu_a"},      32'(alu_operand_A), 32'(0));
        chk({tag, "_alu_b"},      32'(alu_operand_B), 32'(0));
        chk({tag, "_rsp_result"}, 32'(rsp_result),    32'(0));
        chk({tag, "_rsp_carry"},  32'(rsp_carry),     32'(0));
        chk({tag, "_rsp_zero"},   32'(rsp_zero),      32'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // T1 reset
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("post_reset");

        // T2 / T3 single-requester ops
        rsp_ready = 2'b11;
        do_req(0, OP_ADD, 8'hFF, 8'h01, 16'h0100, 1'b1, 1'b0, 1'b1);
        do_req(0, OP_ADD, 8'hFF, 8'h01, 16'h0100, 1'b1, 1'b0, 1'b1);
        do_req(0, OP_MUL, 8'h10, 8'h10, 16'h0100, 1'b0, 1'b0, 1'b1);
        do_req(0, OP_AND, 8'h0F, 8'hF0, 16'h0000, 1'b0, 1'b1, 1'b1);
        do_req(1, OP_SUB, 8'h05, 8'h07, 16'hFFFE, 1'b1, 1'b0, 1'b1);
        do_req(1, OP_OR,  8'h0F, 8'hF0, 16'h00FF, 1'b0, 1'b0, 1'b1);
        drain();

        // T4 both requesters valid from reset: grants alternate 0,1,0,1
        @(posedge clk);
        #1 rst_n = 1'b0;
        set_req(0, OP_ADD, 8'h01, 8'h02);
        set_req(1, OP_OR,  8'h30, 8'h03);
        req_valid = 2'b11;
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) accept(0, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0);
            else            accept(1, 1'b1, 16'h0033, 1'b0, 1'b0, 1'b0);
        end
        req_valid = 2'b00;
        drain();

        // T5 response back-pressure, rsp_ready on the other index ignored
        @(posedge clk);
        #1 rsp_ready = 2'b10;
        do_req(0, OP_ADD, 8'h12, 8'h34, 16'h0046, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        set_req(1, OP_AND, 8'h3C, 8'h0F);
        req_valid[1] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_rsp_valid", 32'(rsp_valid),  32'(1));
            chk("hold_result",    32'(rsp_result), 32'(16'h0046));
            chk("hold_carry",     32'(rsp_carry),  32'(0));
            chk("hold_zero",      32'(rsp_zero),   32'(0));
            chk("hold_req_ready", 32'(req_ready),  32'(0));
            chk("hold_busy",      32'(busy),       32'(1));
        end
        @(posedge clk);
        #1 rsp_ready = 2'b11;
        accept(1, 1'b1, 16'h000C, 1'b0, 1'b0, 1'b1);
        drain();

        // T6 reset during RESP aborts the op and restores requester 0 priority
        do_req(0, OP_NOR, 8'h0F, 8'hF0, 16'h0000, 1'b0, 1'b1, 1'b1);
        @(posedge clk);
        #1 rsp_ready = 2'b00;
        do_req(1, OP_SUB, 8'h09, 8'h03, 16'h0006, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_rsp_valid", 32'(rsp_valid),     32'(0));
        chk("abort_busy",      32'(busy),          32'(0));
        chk("abort_alu_op",    32'(alu_operation), 32'(0));
        @(posedge clk);
        #3 rst_n = 1'b1;
        rsp_ready = 2'b11;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("post_abort_rsp_valid", 32'(rsp_valid), 32'(0));
        end
        @(posedge clk);
        #1;
        set_req(0, OP_XOR, 8'hAA, 8'hAA);
        set_req(1, OP_MUL, 8'h0F, 8'h11);
        req_valid = 2'b11;
        accept(0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1);
        accept(1, 1'b1, 16'h00FF, 1'b0, 1'b0, 1'b1);
        drain();

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
